// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmit path fronted by a small byte FIFO.
//
// Ports:
//   iCE_CLK          system clock, all logic on its rising edge
//   rst              synchronous reset, active-high
//   tx_byte[7:0]     byte to enqueue
//   transmit         enqueue strobe, accepted when ready=1
//   ready            FIFO not full (registered)
//   TX               serial line, idles high (registered)
//   is_transmitting  high from start bit through end of stop bit (registered)
//   fifo_count       bytes waiting, excluding the byte being shifted (registered)
module uart_transmitter #(
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned SYS_CLK_FREQ = 12000000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          iCE_CLK,
  input  logic                          rst,
  input  logic [7:0]                    tx_byte,
  input  logic                          transmit,
  output logic                          ready,
  output logic                          TX,
  output logic                          is_transmitting,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned DIV    = SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               load_pending;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic               push_c;
  logic               pop_c;
  logic               baud_done_c;
  logic               fifo_nonempty_c;
  logic [7:0]         head_c;
  logic [CNT_W-1:0]   count_next_c;

  // Handshake and pop decisions shared by the FIFO and the FSM
  always_comb begin
    push_c          = transmit && ready;
    baud_done_c     = (baud_cnt == BAUD_W'(DIV - 1));
    fifo_nonempty_c = (fifo_count != '0);
    head_c          = mem[rd_ptr];
    // Pop from IDLE one edge before START so TX falls two edges after the write;
    // pop at the end of STOP to chain frames with no idle gap.
    pop_c = fifo_nonempty_c &&
            (((state == IDLE) && !load_pending) ||
             ((state == STOP) && baud_done_c));
  end

  // Next occupancy; a push and pop on the same edge cancel out
  always_comb begin
    count_next_c = fifo_count;
    case ({push_c, pop_c})
      2'b10:   count_next_c = fifo_count + CNT_W'(1);
      2'b01:   count_next_c = fifo_count - CNT_W'(1);
      default: count_next_c = fifo_count;
    endcase
  end

  // FIFO storage, no reset needed on data
  always_ff @(posedge iCE_CLK) begin
    if (push_c) begin
      mem[wr_ptr] <= tx_byte;
    end
  end

  // FIFO pointers and status; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge iCE_CLK) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ready      <= 1'b1;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= count_next_c;
      ready      <= (count_next_c != CNT_W'(FIFO_DEPTH));
    end
  end

  // Transmit FSM with registered TX / is_transmitting
  always_ff @(posedge iCE_CLK) begin
    if (rst) begin
      state           <= IDLE;
      baud_cnt        <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      load_pending    <= 1'b0;
      TX              <= 1'b1;
      is_transmitting <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX              <= 1'b1;
          is_transmitting <= 1'b0;
          baud_cnt        <= '0;
          if (load_pending) begin
            load_pending    <= 1'b0;
            state           <= START;
            TX              <= 1'b0;
            is_transmitting <= 1'b1;
          end else if (pop_c) begin
            shift        <= head_c;
            load_pending <= 1'b1;
          end
        end

        START: begin
          if (baud_done_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            TX       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_done_c) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              TX    <= 1'b1;
            end else begin
              // Next bit is presented straight from shift[1] as the register moves
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
              TX      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_done_c) begin
            baud_cnt <= '0;
            if (pop_c) begin
              shift <= head_c;
              state <= START;
              TX    <= 1'b0;
            end else begin
              state           <= IDLE;
              TX              <= 1'b1;
              is_transmitting <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          state           <= IDLE;
          TX              <= 1'b1;
          is_transmitting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench for uart_transmitter.
// A small-divider instance (DIV=8) covers function; a default instance checks
// the real 1250-cycle bit period.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       transmit = 1'b0;
  logic       ready;
  logic       TX;
  logic       is_transmitting;
  logic [2:0] fifo_count;

  logic [7:0] tx_byte2 = 8'h00;
  logic       transmit2 = 1'b0;
  logic       ready2;
  logic       TX2;
  logic       is_transmitting2;
  logic [2:0] fifo_count2;

  uart_transmitter #(
    .BAUD_RATE(1),
    .SYS_CLK_FREQ(8),
    .FIFO_DEPTH(4)
  ) dut (
    .iCE_CLK(clk),
    .rst(rst),
    .tx_byte(tx_byte),
    .transmit(transmit),
    .ready(ready),
    .TX(TX),
    .is_transmitting(is_transmitting),
    .fifo_count(fifo_count)
  );

  uart_transmitter dut2 (
    .iCE_CLK(clk),
    .rst(rst),
    .tx_byte(tx_byte2),
    .transmit(transmit2),
    .ready(ready2),
    .TX(TX2),
    .is_transmitting(is_transmitting2),
    .fifo_count(fifo_count2)
  );

  // Edge counter: after posedge number k, cyc == k
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  task automatic check(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Park 2 time units after edge k
  task automatic at_edge(input int k);
    while (cyc < k) tick();
    #1;
  endtask

  // Scoreboard monitor: decodes each frame mid-bit and compares with the queue
  logic prev_tx = 1'b1;
  initial begin
    logic [9:0] bits;
    logic [7:0] e;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && prev_tx && !TX) begin
        start_q.push_back(cyc);
        aborted = 1'b0;
        bits    = '0;
        for (int i = 1; i <= 76; i++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
          if (i % 8 == 4) bits[i/8] = TX;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", int'(bits), -1);
          end else begin
            e = exp_q.pop_front();
            check("frame", int'(bits), int'({1'b1, e, 1'b0}));
          end
        end
      end
      prev_tx = TX;
    end
  end

  int n;
  int low;
  int busy;
  int exp_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int exp_cnt[6]   = '{1, 1, 2, 3, 4, 4};
  int exp_rdy[6]   = '{1, 1, 1, 1, 0, 0};

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_tx", int'(TX), 1);
    check("rst_busy", int'(is_transmitting), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_count", int'(fifo_count), 0);
    check("rst_tx2", int'(TX2), 1);
    low = 0;
    repeat (100) begin
      tick();
      if (TX !== 1'b1) low = low + 1;
    end
    check("idle_tx_low_cycles", low, 0);

    // Single byte 0xA5; tx_byte changes right after the write edge
    start_q.delete();
    exp_q.push_back(8'hA5);
    tx_byte = 8'hA5; transmit = 1'b1;
    tick();
    n = cyc;
    transmit = 1'b0; tx_byte = 8'h3C;
    check("single_count_after_write", int'(fifo_count), 1);
    at_edge(n + 1);
    check("single_tx_n1", int'(TX), 1);
    at_edge(n + 2);
    check("single_tx_fall", int'(TX), 0);
    check("single_busy_rise", int'(is_transmitting), 1);
    check("single_count_popped", int'(fifo_count), 0);
    for (int k = 0; k < 10; k++) begin
      at_edge(n + 6 + 8 * k);
      check($sformatf("single_midbit%0d", k), int'(TX), exp_bits[k]);
    end
    at_edge(n + 81);
    check("single_busy_n81", int'(is_transmitting), 1);
    at_edge(n + 82);
    check("single_busy_fall", int'(is_transmitting), 0);
    check("single_tx_idle", int'(TX), 1);
    check("single_frames", start_q.size(), 1);
    if (start_q.size() > 0) check("single_start_edge", start_q[0], n + 2);

    // Burst of six: 0x06 is dropped while full
    repeat (5) tick();
    start_q.delete();
    for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
    for (int i = 0; i < 6; i++) begin
      tx_byte = 8'(i + 1); transmit = 1'b1;
      tick();
      if (i == 0) n = cyc;
      check($sformatf("burst_count%0d", i), int'(fifo_count), exp_cnt[i]);
      check($sformatf("burst_ready%0d", i), int'(ready), exp_rdy[i]);
    end
    transmit = 1'b0;
    for (int k = 1; k < 5; k++) begin
      at_edge(n + 2 + 80 * k);
      check($sformatf("burst_busy_seam%0d", k), int'(is_transmitting), 1);
      check($sformatf("burst_start%0d", k), int'(TX), 0);
    end
    at_edge(n + 401);
    check("burst_busy_last", int'(is_transmitting), 1);
    at_edge(n + 402);
    check("burst_busy_fall", int'(is_transmitting), 0);
    check("burst_frames", start_q.size(), 5);
    for (int k = 0; k < 5 && k < start_q.size(); k++)
      check($sformatf("burst_start_edge%0d", k), start_q[k], n + 2 + 80 * k);

    // Push on the same edge as the STOP->START pop
    repeat (5) tick();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    tx_byte = 8'h11; transmit = 1'b1;
    tick();
    n = cyc;
    tx_byte = 8'h22; tick();
    tx_byte = 8'h33; tick();
    transmit = 1'b0;
    check("simul_count_setup", int'(fifo_count), 2);
    at_edge(n + 81);
    check("simul_count_before", int'(fifo_count), 2);
    tx_byte = 8'h44; transmit = 1'b1;
    tick();
    transmit = 1'b0;
    check("simul_count_after", int'(fifo_count), 2);
    check("simul_restart", int'(TX), 0);
    at_edge(n + 322);
    check("simul_busy_fall", int'(is_transmitting), 0);
    check("simul_count_empty", int'(fifo_count), 0);

    // Reset during data bit 3 of 0xFF with two bytes queued
    repeat (5) tick();
    tx_byte = 8'hFF; transmit = 1'b1;
    tick();
    n = cyc;
    tx_byte = 8'h12; tick();
    tx_byte = 8'h34; tick();
    transmit = 1'b0;
    check("rmid_count_setup", int'(fifo_count), 2);
    at_edge(n + 36);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmid_tx", int'(TX), 1);
    check("rmid_busy", int'(is_transmitting), 0);
    check("rmid_count", int'(fifo_count), 0);
    check("rmid_ready", int'(ready), 1);
    low = 0;
    repeat (200) begin
      tick();
      if (TX !== 1'b1 || is_transmitting !== 1'b0) low = low + 1;
    end
    check("rmid_quiet_cycles", low, 0);
    exp_q.push_back(8'h5A);
    tx_byte = 8'h5A; transmit = 1'b1;
    tick();
    n = cyc;
    transmit = 1'b0;
    at_edge(n + 2);
    check("rmid_new_start", int'(TX), 0);
    at_edge(n + 90);
    check("rmid_new_done", int'(is_transmitting), 0);

    // Default parameters: DIV = 1250
    tx_byte2 = 8'hFF; transmit2 = 1'b1;
    tick();
    transmit2 = 1'b0;
    low = 0; busy = 0;
    repeat (13000) begin
      tick();
      if (TX2 == 1'b0) low = low + 1;
      if (is_transmitting2 == 1'b1) busy = busy + 1;
    end
    check("default_start_width", low, 1250);
    check("default_frame_length", busy, 12500);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
